// File: rtl/rgb_mixer_pkg.sv
// rtl/rgb_mixer_pkg.sv - shared quadrature state and direction definitions
package rgb_mixer_pkg;

   // Gray-coded encoder states, written as {a, b}
   localparam logic [1:0] ENC_00 = 2'b00;
   localparam logic [1:0] ENC_10 = 2'b10;
   localparam logic [1:0] ENC_11 = 2'b11;
   localparam logic [1:0] ENC_01 = 2'b01;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_e;

   // Single-bit Gray moves map to a direction; no change or a double-bit jump is DIR_NONE
   function automatic dir_e decode_dir(input logic [1:0] prev, input logic [1:0] cur);
      dir_e d;
      case ({prev, cur})
         {ENC_00, ENC_10}, {ENC_10, ENC_11}, {ENC_11, ENC_01}, {ENC_01, ENC_00}: d = DIR_UP;
         {ENC_00, ENC_01}, {ENC_01, ENC_11}, {ENC_11, ENC_10}, {ENC_10, ENC_00}: d = DIR_DOWN;
         default: d = DIR_NONE;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - one encoder channel: synchronizer, strobe-gated shift register, level
module debounce #(
   parameter int unsigned LEN = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic strobe,
   input  logic pin,
   output logic level
);

   logic           s1_q;
   logic           s2_q;
   logic [LEN-1:0] sh_q;
   logic           db_q;

   // Two-flop synchronizer, runs every clock regardless of strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= pin;
         s2_q <= s1_q;
      end
   end

   // History of synchronized samples, advanced only on strobe and never cleared between strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_q <= '0;
      end else if (strobe) begin
         sh_q <= {sh_q[LEN-2:0], s2_q};
      end
   end

   // Accept a level only once the whole history agrees; mixed history holds the old level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_q <= 1'b0;
      end else if (&sh_q) begin
         db_q <= 1'b1;
      end else if (~|sh_q) begin
         db_q <= 1'b0;
      end
   end

   assign level = db_q;

endmodule

// File: rtl/quad_encoder.sv
// rtl/quad_encoder.sv - debounced quadrature decoder driving a bounded up/down count
module quad_encoder
   import rgb_mixer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_LEN = 8,
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned WRAP         = 0,
   parameter int unsigned RESET_VALUE  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             strobe,
   input  logic             a,
   input  logic             b,
   output logic [WIDTH-1:0] value,
   output logic             step_up,
   output logic             step_down
);

   logic             a_db;
   logic             b_db;
   logic [1:0]       cur;
   logic [1:0]       prev_q;
   logic [WIDTH-1:0] value_q,   value_d;
   logic             step_up_q, step_up_d;
   logic             step_dn_q, step_dn_d;
   dir_e             dir;

   debounce #(.LEN(DEBOUNCE_LEN)) u_db_a (
      .clk     (clk),
      .reset_n (reset_n),
      .strobe  (strobe),
      .pin     (a),
      .level   (a_db)
   );

   debounce #(.LEN(DEBOUNCE_LEN)) u_db_b (
      .clk     (clk),
      .reset_n (reset_n),
      .strobe  (strobe),
      .pin     (b),
      .level   (b_db)
   );

   assign cur = {a_db, b_db};
   assign dir = decode_dir(prev_q, cur);

   // Next count and step pulses; illegal double jumps fall into DIR_NONE and are ignored
   always_comb begin
      value_d   = value_q;
      step_up_d = 1'b0;
      step_dn_d = 1'b0;
      case (dir)
         DIR_UP: begin
            step_up_d = 1'b1;
            if (WRAP != 0 || value_q != {WIDTH{1'b1}}) begin
               value_d = value_q + WIDTH'(1);
            end
         end
         DIR_DOWN: begin
            step_dn_d = 1'b1;
            if (WRAP != 0 || value_q != '0) begin
               value_d = value_q - WIDTH'(1);
            end
         end
         default: ;
      endcase
   end

   // Decoder state always tracks the debounced pair, even across illegal jumps
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q    <= ENC_00;
         value_q   <= WIDTH'(RESET_VALUE);
         step_up_q <= 1'b0;
         step_dn_q <= 1'b0;
      end else begin
         prev_q    <= cur;
         value_q   <= value_d;
         step_up_q <= step_up_d;
         step_dn_q <= step_dn_d;
      end
   end

   assign value     = value_q;
   assign step_up   = step_up_q;
   assign step_down = step_dn_q;

endmodule

// File: tb/tb_quad_encoder.sv
// tb/tb_quad_encoder.sv - directed bench for quad_encoder (saturating, saturating-at-top, wrapping)
module tb_quad_encoder;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       a;
   logic       b;
   logic       strobe_sel;
   logic [3:0] scnt = 4'd0;
   logic       gen_strobe;
   logic       strobe;

   logic [7:0] v0, v1, v2;
   logic       su0, sd0, su1, sd1, su2, sd2;

   int total = 0;
   int bad   = 0;
   int up0 = 0, dn0 = 0, up1 = 0, dn1 = 0, up2 = 0, dn2 = 0, both = 0;
   int n_strobe = 0;
   int n0;

   always #5 clk = ~clk;

   // one strobe every 9 clocks, as strobe_gen would produce
   always @(posedge clk) scnt <= (scnt == 4'd8) ? 4'd0 : scnt + 4'd1;
   assign gen_strobe = (scnt == 4'd8);
   assign strobe     = strobe_sel ? gen_strobe : 1'b1;

   always @(posedge clk) begin
      if (strobe) n_strobe <= n_strobe + 1;
      if (su0) up0 <= up0 + 1;
      if (sd0) dn0 <= dn0 + 1;
      if (su1) up1 <= up1 + 1;
      if (sd1) dn1 <= dn1 + 1;
      if (su2) up2 <= up2 + 1;
      if (sd2) dn2 <= dn2 + 1;
      if ((su0 && sd0) || (su1 && sd1) || (su2 && sd2)) both <= both + 1;
   end

   quad_encoder #(.DEBOUNCE_LEN(4), .WIDTH(8), .WRAP(0), .RESET_VALUE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .strobe(strobe), .a(a), .b(b),
      .value(v0), .step_up(su0), .step_down(sd0)
   );

   quad_encoder #(.DEBOUNCE_LEN(4), .WIDTH(8), .WRAP(0), .RESET_VALUE(255)) dut_sat (
      .clk(clk), .reset_n(reset_n), .strobe(strobe), .a(a), .b(b),
      .value(v1), .step_up(su1), .step_down(sd1)
   );

   quad_encoder #(.DEBOUNCE_LEN(4), .WIDTH(8), .WRAP(1), .RESET_VALUE(255)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .strobe(strobe), .a(a), .b(b),
      .value(v2), .step_up(su2), .step_down(sd2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic step(input logic na, input logic nb, input int e0, input int e1, input int e2,
                       input string tag);
      a = na;
      b = nb;
      tick(10);
      chk({tag, "_v0"},   v0, e0);
      chk({tag, "_sat"},  v1, e1);
      chk({tag, "_wrap"}, v2, e2);
   endtask

   initial begin
      reset_n    = 1'b0;
      a          = 1'b1;
      b          = 1'b1;
      strobe_sel = 1'b0;
      tick(3);
      chk("rst_v0", v0, 0);
      chk("rst_sat", v1, 255);
      chk("rst_wrap", v2, 255);
      chk("rst_up", su0, 0);

      // pins idle high: both channels settle together, no count
      reset_n = 1'b1;
      tick(15);
      chk("idle11_v0", v0, 0);
      chk("idle11_steps", up0 + dn0 + up1 + dn1 + up2 + dn2, 0);

      // double jump 11 -> 00 is ignored
      a = 1'b0;
      b = 1'b0;
      tick(15);
      chk("ill_v0", v0, 0);
      chk("ill_steps", up0 + dn0, 0);

      // first forward step: exact 8-clock latency
      a = 1'b1;
      tick(7);
      chk("lat7_v0", v0, 0);
      chk("lat7_up", su0, 0);
      tick(1);
      chk("lat8_v0", v0, 1);
      chk("lat8_up", su0, 1);
      chk("lat8_sat_up", su1, 1);
      chk("lat8_sat_v", v1, 255);
      chk("lat8_wrap_v", v2, 0);
      tick(1);
      chk("lat9_up", su0, 0);
      tick(1);

      step(1'b1, 1'b1, 2, 255, 1, "fwd2");
      step(1'b0, 1'b1, 3, 255, 2, "fwd3");
      step(1'b0, 1'b0, 4, 255, 3, "fwd4");
      chk("fwd_upcnt", up0, 4);

      step(1'b0, 1'b1, 3, 254, 2,   "rev1");
      step(1'b1, 1'b1, 2, 253, 1,   "rev2");
      step(1'b1, 1'b0, 1, 252, 0,   "rev3");
      step(1'b0, 1'b0, 0, 251, 255, "rev4");
      chk("rev_dncnt", dn0, 4);

      // 3-clock glitch on a is rejected
      a = 1'b1;
      tick(3);
      a = 1'b0;
      tick(15);
      chk("g3_v0", v0, 0);
      chk("g3_sat", v1, 251);
      chk("g3_upcnt", up0, 4);

      // 4-clock pulse is accepted: +1 then -1
      a = 1'b1;
      tick(4);
      a = 1'b0;
      tick(4);
      chk("g4_up_v0", v0, 1);
      chk("g4_up_sat", v1, 252);
      chk("g4_up_wrap", v2, 0);
      tick(10);
      chk("g4_dn_v0", v0, 0);
      chk("g4_dn_sat", v1, 251);
      chk("g4_dn_wrap", v2, 255);

      // reverse at 0 holds on the saturating counter but still pulses
      step(1'b0, 1'b1, 0, 250, 254, "rev_sat0");
      chk("rev_sat0_dncnt", dn0, 6);
      chk("rev_sat0_upcnt", up0, 5);

      // seven forward steps from 01
      step(1'b0, 1'b0, 1, 251, 255, "f7a");
      step(1'b1, 1'b0, 2, 252, 0,   "f7b");
      step(1'b1, 1'b1, 3, 253, 1,   "f7c");
      step(1'b0, 1'b1, 4, 254, 2,   "f7d");
      step(1'b0, 1'b0, 5, 255, 3,   "f7e");
      step(1'b1, 1'b0, 6, 255, 4,   "f7f");
      step(1'b1, 1'b1, 7, 255, 5,   "f7g");

      a = 1'b0;
      b = 1'b0;
      tick(12);
      chk("ill2_v0", v0, 7);
      chk("ill2_wrap", v2, 5);

      // asynchronous reset between clock edges
      #2 reset_n = 1'b0;
      #1;
      chk("arst_v0", v0, 0);
      chk("arst_sat", v1, 255);
      chk("arst_wrap", v2, 255);
      tick(2);
      reset_n = 1'b1;
      tick(12);
      chk("post_rst_v0", v0, 0);
      step(1'b1, 1'b0, 1, 255, 0, "post_rst_fwd");

      // real strobe: one pulse per 9 clocks
      strobe_sel = 1'b1;
      tick(20);
      n0 = n_strobe;
      b  = 1'b1;
      tick(27);
      chk("rs_early_v0", v0, 1);
      for (int i = 0; i < 80; i++) begin
         if (v0 !== 8'd1) break;
         tick(1);
      end
      chk("rs_v0", v0, 2);
      chk("rs_strobes_4or5", ((n_strobe - n0) >= 4 && (n_strobe - n0) <= 5) ? 1 : 0, 1);

      chk("never_both", both, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
